// File: rtl/rf_wb_sched.sv
// Write-back scheduler: arbitrates ALU/LSU/link results onto the single register
// file write port and tracks outstanding writes per register for hazard checks.
module rf_wb_sched #(
  parameter int unsigned Width   = 32,
  parameter int unsigned AddrW   = 5,
  parameter int unsigned MaxWait = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              iss_valid_i,
  input  logic [AddrW-1:0]  iss_rd_i,
  input  logic              alu_valid_i,
  input  logic [AddrW-1:0]  alu_rd_i,
  input  logic [Width-1:0]  alu_data_i,
  output logic              alu_ready_o,
  input  logic              lsu_valid_i,
  input  logic [AddrW-1:0]  lsu_rd_i,
  input  logic [Width-1:0]  lsu_data_i,
  output logic              lsu_ready_o,
  input  logic              lnk_valid_i,
  input  logic [AddrW-1:0]  lnk_rd_i,
  input  logic [Width-1:0]  lnk_data_i,
  output logic              lnk_ready_o,
  output logic              RegWEn_o,
  output logic [AddrW-1:0]  RW_o,
  output logic [Width-1:0]  busW_o,
  input  logic [AddrW-1:0]  RA_i,
  input  logic [AddrW-1:0]  RB_i,
  output logic              busy_a_o,
  output logic              busy_b_o,
  output logic              busy_w_o
);

  localparam int unsigned NumRegs = 1 << AddrW;
  localparam int unsigned CntW    = 4;

  logic [CntW-1:0]    wait_q, wait_d;
  logic [NumRegs-1:0] pend_q, pend_d;
  logic               we_d;
  logic [AddrW-1:0]   rw_d;
  logic [Width-1:0]   bus_d;
  logic               force_alu;
  logic               acc;
  logic [AddrW-1:0]   acc_rd;
  logic [Width-1:0]   acc_data;

  // Priority lnk > lsu > alu, unless the ALU has starved for MaxWait cycles
  always_comb begin
    force_alu   = alu_valid_i && (wait_q == CntW'(MaxWait));
    lnk_ready_o = lnk_valid_i && !force_alu;
    lsu_ready_o = lsu_valid_i && !lnk_valid_i && !force_alu;
    alu_ready_o = alu_valid_i && (force_alu || (!lnk_valid_i && !lsu_valid_i));
    acc         = lnk_ready_o || lsu_ready_o || alu_ready_o;
    acc_rd      = alu_rd_i;
    acc_data    = alu_data_i;
    if (lnk_ready_o) begin
      acc_rd   = lnk_rd_i;
      acc_data = lnk_data_i;
    end else if (lsu_ready_o) begin
      acc_rd   = lsu_rd_i;
      acc_data = lsu_data_i;
    end
  end

  // Next state for counter, scoreboard and write port; a same-cycle issue overrides the clear
  always_comb begin
    wait_d = wait_q;
    pend_d = pend_q;
    we_d   = 1'b0;
    rw_d   = RW_o;
    bus_d  = busW_o;
    if (alu_ready_o) begin
      wait_d = '0;
    end else if (alu_valid_i && (wait_q < CntW'(MaxWait))) begin
      wait_d = wait_q + CntW'(1);
    end
    if (acc) begin
      we_d  = (acc_rd != '0);
      rw_d  = acc_rd;
      bus_d = acc_data;
      if (acc_rd != '0) pend_d[acc_rd] = 1'b0;
    end
    if (iss_valid_i && (iss_rd_i != '0)) pend_d[iss_rd_i] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wait_q   <= '0;
      pend_q   <= '0;
      RegWEn_o <= 1'b0;
      RW_o     <= '0;
      busW_o   <= '0;
    end else begin
      wait_q   <= wait_d;
      pend_q   <= pend_d;
      RegWEn_o <= we_d;
      RW_o     <= rw_d;
      busW_o   <= bus_d;
    end
  end

  // A register stays busy until its write has left the registered write port
  function automatic logic is_busy(input logic [AddrW-1:0] a);
    return (a != '0) && (pend_q[a] || (RegWEn_o && (RW_o == a)));
  endfunction

  always_comb begin
    busy_a_o = is_busy(RA_i);
    busy_b_o = is_busy(RB_i);
    busy_w_o = is_busy(iss_rd_i);
  end

endmodule

// File: doc/rf_wb_sched.md
Name: rf_wb_sched

Overview:
- Write-back scheduler for the 32-entry register file. It shares the file's single write port (RegWEn/RW/busW) between three result sources: ALU, load/store unit (LSU) and the jal/jalr link-address path.
- It keeps a pending-write scoreboard per register so issue logic can detect RAW/WAW hazards on the RA/RB/rd addresses.
- It sits between the execute/memory stages and the register file.

Parameters:
- Width, 32, data width of result buses and busW_o
- AddrW, 5, register address width (32 registers)
- MaxWait, 4, ALU starvation limit in cycles before the ALU is forced to top priority (range 1..15)

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-high reset
- iss_valid_i  in  1  an instruction with a destination register issues this cycle
- iss_rd_i  in  AddrW  destination register of the issuing instruction
- alu_valid_i  in  1  ALU result valid
- alu_rd_i  in  AddrW  ALU destination register
- alu_data_i  in  Width  ALU result
- alu_ready_o  out  1  ALU result accepted this cycle
- lsu_valid_i / lsu_rd_i / lsu_data_i / lsu_ready_o  same widths, load result (already sign/zero-extended)
- lnk_valid_i / lnk_rd_i / lnk_data_i / lnk_ready_o  same widths, link address (pc+4)
- RegWEn_o  out  1  register file write enable
- RW_o  out  AddrW  register file write address
- busW_o  out  Width  register file write data
- RA_i, RB_i  in  AddrW  source addresses being checked
- busy_a_o, busy_b_o  out  1  the RA/RB register has a write outstanding
- busy_w_o  out  1  iss_rd_i has a write outstanding (WAW)

Behaviour:
- Reset (async, while rst_i=1): RegWEn_o=0, RW_o=0, busW_o=0, wait counter=0, pending[31:0]=0. Any result in flight is dropped.
- Handshake: a transfer happens when valid&&ready. Ready outputs are combinational from the current valids and the wait counter. A source holds rd and data stable while valid&&!ready. Exactly one ready is high per cycle; none is high if no source is valid.
- Arbitration order is lnk > lsu > alu.
  - Exception: when the wait counter == MaxWait and alu_valid_i=1, the ALU wins over both other sources.
- Wait counter:
  - increments each cycle alu_valid_i&&!alu_ready_o, saturating at MaxWait;
  - clears on ALU accept;
  - holds while alu_valid_i=0.
- Write port: registered with 1-cycle latency. On the edge after an accept, RegWEn_o=1 (0 if the accepted rd==0), RW_o=rd, busW_o=data. If there is no accept, RegWEn_o=0 and RW_o/busW_o hold their values.
- Scoreboard pending[31:1]; pending[0] is constant 0.
  - Set at the edge when iss_valid_i&&iss_rd_i!=0.
  - Cleared at the edge when an accept writes that rd.
  - If a set and a clear hit the same register in one cycle, the set wins: the new producer is outstanding.
- Busy outputs (combinational):
  - busy_a_o = RA_i!=0 && (pending[RA_i] || (RegWEn_o && RW_o==RA_i)). The second term covers the cycle where the write is registered but not yet in the file.
  - busy_b_o uses the same rule with RB_i.
  - busy_w_o uses the same rule with iss_rd_i.
- A write to rd==0 is accepted normally (ready asserted, counter updated) but never raises RegWEn_o and never touches the scoreboard.
- An accept for a register with pending=0 is legal: the write occurs and the scoreboard is unchanged.

Test Plan:
- Reset then idle → RegWEn_o=0, RW_o=0, busW_o=0, all ready=0, all busy=0. Assert rst_i mid-transfer → outputs clear without waiting for a clock edge.
- alu_valid_i=1, rd=5, data=0x1234 alone → alu_ready_o=1 that cycle. Next cycle: RegWEn_o=1, RW_o=5, busW_o=0x00001234. The cycle after: RegWEn_o=0.
- lnk(rd=1, 0x100), lsu(rd=7, 0xFF) and alu(rd=3) all valid in one cycle → lnk accepted first, then lsu next cycle. ALU accepted once nothing higher-priority is valid.
- lsu_valid_i held high continuously with alu_valid_i=1 (rd=9), MaxWait=4 → ALU stalls 4 cycles, then is accepted in the 5th cycle. Counter returns to 0.
- Issue rd=10, then RA_i=10 → busy_a_o=1 until the ALU write to 10 has passed through RegWEn_o. busy_a_o=0 the cycle after RegWEn_o drops.
- iss_valid_i rd=12 in the same cycle an accept writes rd=12 → pending[12] stays 1. Separately, alu rd=0 with data 0xDEAD → alu_ready_o=1, RegWEn_o stays 0, and busy_a_o with RA_i=0 stays 0.
